// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the memory arbiter: FSM state encoding and
//               a round-robin index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Raw encodings kept as explicit-width constants for tools and scripts that
  // only understand plain vectors; the enum below is built on them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    DONE  = ST_DONE
  } arb_state_e;

  // Next requester index after idx, wrapping at n-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Scans the request vector
//               upward from ptr, wrapping at NumReq-1, and reports the first
//               requester found.
// Ports       : req    - request vector
//               ptr    - index where the search starts
//               winner - selected requester index (0 when valid is low)
//               valid  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NumReq   = 4,
  parameter int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] winner,
  output logic                valid
);

  int                  pos;
  logic [IdxWidth-1:0] idx;

  // Scan from the farthest offset down to offset 0 so that the requester
  // closest to ptr is written last and therefore wins.
  always_comb begin
    winner = '0;
    valid  = |req;
    pos    = 0;
    idx    = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= NumReq) pos = pos - NumReq;
      idx = IdxWidth'(pos);
      if (req[idx]) winner = idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter and sequencer sharing one single-port
//               memory among NumReq requesters. One transaction at a time:
//               grant, one-cycle read/write strobe, wait the read latency,
//               then a one-cycle acknowledge carrying read data.
// Ports       : clk, rst_n                   - clock, async active-low reset
//               req/req_we/req_addr/req_wdata - per-requester command
//               ack, rdata                    - one-hot completion, read data
//               busy                          - transaction in progress
//               mem_addr/mem_data_in          - registered memory command
//               mem_read/mem_write            - registered one-cycle strobes
//               mem_data_out                  - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AddrWidth   = 5,
  parameter int DataWidth   = 8,
  parameter int NumReq      = 4,
  parameter int ReadLatency = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumReq-1:0]                  req,
  input  logic [NumReq-1:0]                  req_we,
  input  logic [NumReq-1:0][AddrWidth-1:0]   req_addr,
  input  logic [NumReq-1:0][DataWidth-1:0]   req_wdata,
  output logic [NumReq-1:0]                  ack,
  output logic [DataWidth-1:0]               rdata,
  output logic                               busy,
  output logic [AddrWidth-1:0]               mem_addr,
  output logic [DataWidth-1:0]               mem_data_in,
  output logic                               mem_read,
  output logic                               mem_write,
  input  logic [DataWidth-1:0]               mem_data_out
);

  localparam int IdxWidth = $clog2(NumReq);
  localparam int CntWidth = $clog2(ReadLatency + 1);

  arb_state_e          state;
  logic [IdxWidth-1:0] ptr;
  logic [IdxWidth-1:0] win_idx;
  logic                cmd_we;
  logic [CntWidth-1:0] lat_cnt;

  logic [IdxWidth-1:0] grant_idx;
  logic                grant_valid;
  logic [NumReq-1:0]   ack_onehot;

  rr_arbiter #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr),
    .winner (grant_idx),
    .valid  (grant_valid)
  );

  assign ack_onehot = NumReq'(1) << win_idx;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      win_idx     <= '0;
      cmd_we      <= 1'b0;
      lat_cnt     <= '0;
      ack         <= '0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      // Strobes and ack are single-cycle pulses unless set below.
      ack       <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            // The memory address/data registers double as the latched
            // command, so they are loaded at grant and are already valid
            // (together with the strobe) for the whole ISSUE cycle.
            win_idx     <= grant_idx;
            cmd_we      <= req_we[grant_idx];
            mem_addr    <= req_addr[grant_idx];
            mem_data_in <= req_wdata[grant_idx];
            mem_write   <= req_we[grant_idx];
            mem_read    <= ~req_we[grant_idx];
            ptr         <= IdxWidth'(next_idx(int'(grant_idx), NumReq));
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            ack   <= ack_onehot;
            state <= DONE;
          end else begin
            lat_cnt <= CntWidth'(ReadLatency);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - CntWidth'(1);
          if (lat_cnt == CntWidth'(1)) begin
            rdata <= mem_data_out;
            ack   <= ack_onehot;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Instance a uses
//               ReadLatency=1, instance b uses ReadLatency=3; each has its
//               own pipelined memory model and expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NR-1:0]         a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [NR-1:0][AW-1:0] a_addr, b_addr;
  logic [NR-1:0][DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0]         a_rdata, b_rdata, a_mem_data_in, b_mem_data_in;
  logic [DW-1:0]         a_mem_data_out, b_mem_data_out;
  logic [AW-1:0]         a_mem_addr, b_mem_addr;
  logic                  a_busy, b_busy, a_mem_read, b_mem_read, a_mem_write, b_mem_write;

  mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .NumReq(NR), .ReadLatency(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_we(a_we), .req_addr(a_addr),
    .req_wdata(a_wdata), .ack(a_ack), .rdata(a_rdata), .busy(a_busy),
    .mem_addr(a_mem_addr), .mem_data_in(a_mem_data_in), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_data_out(a_mem_data_out));

  mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .NumReq(NR), .ReadLatency(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_we(b_we), .req_addr(b_addr),
    .req_wdata(b_wdata), .ack(b_ack), .rdata(b_rdata), .busy(b_busy),
    .mem_addr(b_mem_addr), .mem_data_in(b_mem_data_in), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_data_out(b_mem_data_out));

  // Memory models: data is presented for exactly one cycle, ReadLatency
  // cycles after the edge that samples the read strobe.
  logic [DW-1:0] a_mem [32];
  logic [DW-1:0] b_mem [32];
  logic [DW-1:0] a_pipe;
  logic [DW-1:0] b_pipe [3];

  always @(posedge clk) begin
    if (a_mem_write) a_mem[a_mem_addr] <= a_mem_data_in;
    a_pipe <= a_mem_read ? a_mem[a_mem_addr] : '0;
    if (b_mem_write) b_mem[b_mem_addr] <= b_mem_data_in;
    b_pipe[0] <= b_mem_read ? b_mem[b_mem_addr] : '0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_mem_data_out = a_pipe;
  assign b_mem_data_out = b_pipe[2];

  typedef struct {
    logic [NR-1:0] ack;
    logic          rd;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected completion whenever an ack appears.
  always @(negedge clk) begin
    if (a_mem_read && a_mem_write) begin
      compared++; mismatched++;
      $display("FAIL a_strobes: read=%b write=%b expected not both", a_mem_read, a_mem_write);
    end
    if (b_mem_read && b_mem_write) begin
      compared++; mismatched++;
      $display("FAIL b_strobes: read=%b write=%b expected not both", b_mem_read, b_mem_write);
    end
    if (a_ack != '0) begin
      if (qa.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL a_unexpected_ack: got %b expected none (cycle %0d)", a_ack, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_ack", 32'(a_ack), 32'(ea.ack));
        chk("a_ack_cycle", cyc, ea.cyc);
        if (ea.rd) chk("a_rdata", 32'(a_rdata), 32'(ea.rdata));
      end
    end
    if (b_ack != '0) begin
      if (qb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL b_unexpected_ack: got %b expected none (cycle %0d)", b_ack, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_ack", 32'(b_ack), 32'(eb.ack));
        chk("b_ack_cycle", cyc, eb.cyc);
        if (eb.rd) chk("b_rdata", 32'(b_rdata), 32'(eb.rdata));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int t;

  initial begin
    rst_n = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_ack", 32'(a_ack), 0);
    chk("rst_mem_read", 32'(a_mem_read), 0);
    chk("rst_mem_write", 32'(a_mem_write), 0);
    chk("rst_mem_addr", 32'(a_mem_addr), 0);
    chk("rst_rdata", 32'(a_rdata), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Requester 0 writes A5 to 03: strobe at T+1, ack at T+2.
    t = cyc;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 5'h03; a_wdata[0] = 8'hA5;
    qa.push_back('{ack: 4'b0001, rd: 1'b0, rdata: 8'h00, cyc: t + 2});
    tick();
    @(negedge clk);
    chk("wr_mem_write", 32'(a_mem_write), 1);
    chk("wr_mem_read", 32'(a_mem_read), 0);
    chk("wr_mem_addr", 32'(a_mem_addr), 32'h03);
    chk("wr_mem_data_in", 32'(a_mem_data_in), 32'hA5);
    chk("wr_busy", 32'(a_busy), 1);
    tick();
    a_req[0] = 1'b0;
    repeat (3) tick();

    // Requester 2 reads 03 back (ReadLatency=1): ack at T+3 with A5.
    t = cyc;
    a_req[2] = 1'b1; a_we[2] = 1'b0; a_addr[2] = 5'h03;
    qa.push_back('{ack: 4'b0100, rd: 1'b1, rdata: 8'hA5, cyc: t + 3});
    tick();
    @(negedge clk);
    chk("rd_mem_read", 32'(a_mem_read), 1);
    chk("rd_mem_addr", 32'(a_mem_addr), 32'h03);
    repeat (2) tick();
    a_req[2] = 1'b0;
    repeat (3) tick();

    // ptr is now 3; requesters 0 and 1 together: 0 wins by wrap, then 1.
    t = cyc;
    a_req = 4'b0011; a_we = 4'b0011;
    a_addr[0] = 5'h10; a_wdata[0] = 8'hC0;
    a_addr[1] = 5'h11; a_wdata[1] = 8'hC1;
    qa.push_back('{ack: 4'b0001, rd: 1'b0, rdata: 8'h00, cyc: t + 2});
    qa.push_back('{ack: 4'b0010, rd: 1'b0, rdata: 8'h00, cyc: t + 5});
    tick();
    @(negedge clk);
    chk("wrap_first_addr", 32'(a_mem_addr), 32'h10);
    tick();
    a_req[0] = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("wrap_second_addr", 32'(a_mem_addr), 32'h11);
    chk("wrap_second_write", 32'(a_mem_write), 1);
    tick();
    a_req[1] = 1'b0;
    repeat (3) tick();

    // Requester 3 read, reset pulsed during WAIT: no ack may follow.
    a_we = '0;
    a_req[3] = 1'b1; a_addr[3] = 5'h03;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", 32'(a_busy), 0);
    chk("rstw_mem_read", 32'(a_mem_read), 0);
    chk("rstw_ack", 32'(a_ack), 0);
    chk("rstw_rdata", 32'(a_rdata), 0);
    a_req[3] = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // All four held after reset: grants 0,1,2,3,0 every 3 cycles.
    t = cyc;
    a_req = 4'b1111; a_we = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      a_addr[i]  = AW'(i + 4);
      a_wdata[i] = DW'(8'h50 + i);
    end
    qa.push_back('{ack: 4'b0001, rd: 1'b0, rdata: 8'h00, cyc: t + 2});
    qa.push_back('{ack: 4'b0010, rd: 1'b0, rdata: 8'h00, cyc: t + 5});
    qa.push_back('{ack: 4'b0100, rd: 1'b0, rdata: 8'h00, cyc: t + 8});
    qa.push_back('{ack: 4'b1000, rd: 1'b0, rdata: 8'h00, cyc: t + 11});
    qa.push_back('{ack: 4'b0001, rd: 1'b0, rdata: 8'h00, cyc: t + 14});
    tick();
    @(negedge clk);
    chk("all4_first_addr", 32'(a_mem_addr), 32'h04);
    while (cyc < t + 14) tick();
    a_req = '0;
    repeat (3) tick();

    // Instance b (ReadLatency=3): write 3C to 1F, then read it back.
    t = cyc;
    b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = 5'h1F; b_wdata[1] = 8'h3C;
    qb.push_back('{ack: 4'b0010, rd: 1'b0, rdata: 8'h00, cyc: t + 2});
    repeat (2) tick();
    b_req[1] = 1'b0;
    repeat (3) tick();

    t = cyc;
    b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 5'h1F;
    qb.push_back('{ack: 4'b0010, rd: 1'b1, rdata: 8'h3C, cyc: t + 5});
    tick();
    // Command changes after grant must be ignored.
    b_addr[1] = 5'h00; b_we[1] = 1'b1; b_wdata[1] = 8'hFF;
    @(negedge clk);
    chk("b_rd_mem_read", 32'(b_mem_read), 1);
    chk("b_rd_mem_addr", 32'(b_mem_addr), 32'h1F);
    tick();
    @(negedge clk);
    chk("b_wait_mem_addr", 32'(b_mem_addr), 32'h1F);
    chk("b_wait_mem_write", 32'(b_mem_write), 0);
    while (cyc < t + 5) tick();
    b_req[1] = 1'b0;
    repeat (4) tick();

    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
